control_multi_fsm: RTL
======================

// Module: control_multi_fsm
// PURPOSE
//  Multicycle RV32I(+M) control unit: Moore FSM that sequences the shared ALU, register file and unified memory over several cycles per instruction.
//  Decodes the instruction held in the IR, using OPC_*/FUNCT3_*/FUNCT7_* and OP* codes from Parametros.v.
//  Drives all datapath mux selects and write enables, and stalls on memory and mul/div handshakes.
// PARAMETERS
//  MEM_WAIT_EN  1  1: memory states hold until iMemReady=1; 0: iMemReady ignored (treated as 1)
//  MULDIV_EN    1  1: FUNCT7_MULDIV R-type legal, R_EXEC holds until iMulDivDone=1; 0: treated as illegal
// PORTS
//  iCLK          in   1   clock, rising edge
//  iRST          in   1   reset, asynchronous, active-low
//  iInstr        in   32  current IR contents
//  iMemReady     in   1   memory access completes this cycle
//  iMulDivDone   in   1   mul/div result valid this cycle
//  oEscreveIR    out  1   load IR from memory data
//  oEscrevePC    out  1   unconditional PC write
//  oEscrevePCCond out 1   PC write if datapath branch condition true
//  oEscrevePCBack out 1   PCBack <= PC
//  oIouD         out  1   memory address: 0=PC, 1=ALUOut
//  oMemRead      out  1   memory read strobe
//  oMemWrite     out  1   memory write strobe
//  oRegWrite     out  1   register file write
//  oOrigAULA     out  2   ALU A: 00=rs1, 01=PC, 10=PCBack
//  oOrigBULA     out  2   ALU B: 00=rs2, 01=const 4, 10=imm
//  oMem2Reg      out  2   rd source: 00=ALUOut, 01=PC, 10=MemData
//  oOrigPC       out  2   PC source: 00=ALU result, 01=ALUOut, 10=ALUOut(JAL), 11=ALU result with bit0 cleared (JALR)
//  oALUControl   out  5   ALU operation (OP* codes)
//  oIllegal      out  1   one-cycle illegal-instruction pulse
//  oState        out  4   current state encoding (debug)
// BEHAVIOUR
//  Reset:
//  - iRST=0 forces state FETCH (0) immediately.
//  - While iRST=0, every output is 0, including oALUControl=OPNULL.
//  - Reset mid-access aborts the access; no retry occurs.
//  Outputs:
//  - Combinational from state (and IR funct fields in EXEC states).
//  - Any output not listed for a state is 0; oALUControl defaults to OPNULL.
//  States (code: actions -> next):
//  - FETCH(0): IouD=0, MemRead, A=01, B=01, OPADD. On ready: EscreveIR, EscrevePC (OrigPC=00), EscrevePCBack -> DECODE. Else hold.
//  - DECODE(1): A=10, B=10, OPADD (branch/JAL target into ALUOut). Next by opcode:
//    LOAD/STORE->ADDR, OPIMM->I_EXEC, RTYPE->R_EXEC, AUIPC->AUIPC, LUI->LUI, BRANCH->BRANCH, JAL->JAL, JALR->JALR, other->ILLEGAL.
//  - ADDR(2): A=00, B=10, OPADD -> LW_MEM if LOAD, else SW_MEM.
//  - LW_MEM(3): IouD=1, MemRead; on ready -> LW_WB.
//  - LW_WB(4): Mem2Reg=10, RegWrite -> FETCH.
//  - SW_MEM(5): IouD=1, MemWrite held until ready -> FETCH.
//  - R_EXEC(6): A=00, B=00; ALU op from funct3/funct7, SUB/SRA via FUNCT7_SUB.
//    Mul/div: hold until iMulDivDone -> ALU_WB.
//    Illegal funct3/funct7 combinations are detected in DECODE and go to ILLEGAL.
//  - I_EXEC(7): A=00, B=10; op from funct3 (SRAI via funct7) -> ALU_WB.
//  - AUIPC(8): A=10, B=10, OPADD -> ALU_WB.
//  - LUI(9): B=10, OPLUI -> ALU_WB.
//  - ALU_WB(10): Mem2Reg=00, RegWrite -> FETCH.
//  - BRANCH(11): A=00, B=00, OPSUB, EscrevePCCond, OrigPC=01 -> FETCH.
//  - JAL(12): Mem2Reg=01, RegWrite, EscrevePC, OrigPC=10 -> FETCH.
//  - JALR(13): A=00, B=10, OPADD, Mem2Reg=01, RegWrite, EscrevePC, OrigPC=11 -> FETCH.
//  - ILLEGAL(14): oIllegal=1, no writes -> FETCH. PC already advanced.
//  Latency with zero wait states:
//  - 3 cycles: BRANCH, JAL, JALR.
//  - 4 cycles: ALU ops, LUI, AUIPC, store.
//  - 5 cycles: load.
//  - Each memory wait cycle adds 1.
//  Boundary rules:
//  - iMemReady high outside a memory state is ignored.
//  - iMulDivDone high outside R_EXEC is ignored.
//  - Write strobes stay asserted across every wait cycle; write enables (IR/PC/Reg) fire only on the completing cycle.
//  - Unused code 15 -> FETCH next cycle with all outputs 0.
// TESTING
//  add x3,x1,x2 (0x002081B3), ready=1:
//    states 0,1,6,10,0; OPADD in 6; RegWrite only in 10.
//  lw x5,8(x1) (0x0080A283), 2 wait cycles in LW_MEM:
//    LW_MEM lasts 3 cycles; RegWrite with Mem2Reg=10 exactly once.
//  sw with iMemReady low 4 cycles:
//    MemWrite high 5 consecutive cycles; IouD=1 throughout.
//  beq (0x00208463), jal (0x008000EF), jalr (0x000080E7):
//    3-cycle sequences; OrigPC = 01, 10, 11 respectively.
//  Opcode 0x7F, and RTYPE with funct7=0x20 funct3=001:
//    oIllegal pulses once; no RegWrite/MemWrite/PC write after FETCH.
//  iRST low in SW_MEM mid-wait:
//    MemWrite drops the same cycle; after release, FETCH with MemRead=1.

Source files
------------

// File: rtl/control_multi_fsm_if.sv
// Control bus between the multicycle control FSM and the RV32I datapath.
// master = control unit side, slave = datapath side.
interface control_multi_fsm_if;
  logic [31:0] iInstr;
  logic        iMemReady;
  logic        iMulDivDone;
  logic        oEscreveIR;
  logic        oEscrevePC;
  logic        oEscrevePCCond;
  logic        oEscrevePCBack;
  logic        oIouD;
  logic        oMemRead;
  logic        oMemWrite;
  logic        oRegWrite;
  logic [1:0]  oOrigAULA;
  logic [1:0]  oOrigBULA;
  logic [1:0]  oMem2Reg;
  logic [1:0]  oOrigPC;
  logic [4:0]  oALUControl;
  logic        oIllegal;
  logic [3:0]  oState;

  modport master (
    input  iInstr, iMemReady, iMulDivDone,
    output oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack, oIouD,
           oMemRead, oMemWrite, oRegWrite, oOrigAULA, oOrigBULA, oMem2Reg,
           oOrigPC, oALUControl, oIllegal, oState
  );

  modport slave (
    output iInstr, iMemReady, iMulDivDone,
    input  oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack, oIouD,
           oMemRead, oMemWrite, oRegWrite, oOrigAULA, oOrigBULA, oMem2Reg,
           oOrigPC, oALUControl, oIllegal, oState
  );
endinterface

// File: rtl/control_multi_fsm.sv
// Multicycle RV32I(+M) control unit: Moore FSM sequencing the shared ALU,
// register file and unified memory over several cycles per instruction.
module control_multi_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit MULDIV_EN   = 1'b1
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  control_multi_fsm_if.master    bus
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 5;

  localparam logic [STATE_W-1:0] ST_FETCH   = 4'd0;
  localparam logic [STATE_W-1:0] ST_DECODE  = 4'd1;
  localparam logic [STATE_W-1:0] ST_ADDR    = 4'd2;
  localparam logic [STATE_W-1:0] ST_LW_MEM  = 4'd3;
  localparam logic [STATE_W-1:0] ST_LW_WB   = 4'd4;
  localparam logic [STATE_W-1:0] ST_SW_MEM  = 4'd5;
  localparam logic [STATE_W-1:0] ST_R_EXEC  = 4'd6;
  localparam logic [STATE_W-1:0] ST_I_EXEC  = 4'd7;
  localparam logic [STATE_W-1:0] ST_AUIPC   = 4'd8;
  localparam logic [STATE_W-1:0] ST_LUI     = 4'd9;
  localparam logic [STATE_W-1:0] ST_ALU_WB  = 4'd10;
  localparam logic [STATE_W-1:0] ST_BRANCH  = 4'd11;
  localparam logic [STATE_W-1:0] ST_JAL     = 4'd12;
  localparam logic [STATE_W-1:0] ST_JALR    = 4'd13;
  localparam logic [STATE_W-1:0] ST_ILLEGAL = 4'd14;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [ALU_W-1:0] OPAND    = 5'd0;
  localparam logic [ALU_W-1:0] OPOR     = 5'd1;
  localparam logic [ALU_W-1:0] OPXOR    = 5'd2;
  localparam logic [ALU_W-1:0] OPADD    = 5'd3;
  localparam logic [ALU_W-1:0] OPSUB    = 5'd4;
  localparam logic [ALU_W-1:0] OPSLT    = 5'd5;
  localparam logic [ALU_W-1:0] OPSLTU   = 5'd6;
  localparam logic [ALU_W-1:0] OPSLL    = 5'd7;
  localparam logic [ALU_W-1:0] OPSRL    = 5'd8;
  localparam logic [ALU_W-1:0] OPSRA    = 5'd9;
  localparam logic [ALU_W-1:0] OPLUI    = 5'd10;
  localparam logic [ALU_W-1:0] OPMUL    = 5'd11;
  localparam logic [ALU_W-1:0] OPMULH   = 5'd12;
  localparam logic [ALU_W-1:0] OPMULHU  = 5'd13;
  localparam logic [ALU_W-1:0] OPMULHSU = 5'd14;
  localparam logic [ALU_W-1:0] OPDIV    = 5'd15;
  localparam logic [ALU_W-1:0] OPDIVU   = 5'd16;
  localparam logic [ALU_W-1:0] OPREM    = 5'd17;
  localparam logic [ALU_W-1:0] OPREMU   = 5'd18;
  localparam logic [ALU_W-1:0] OPNULL   = 5'd31;

  logic [STATE_W-1:0] state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_fields;

  assign opcode = bus.iInstr[6:0];
  assign funct3 = bus.iInstr[14:12];
  assign funct7 = bus.iInstr[31:25];
  assign unused_instr_fields = ^{bus.iInstr[24:15], bus.iInstr[11:7]};

  logic mem_ready;
  logic is_muldiv;
  logic r_legal;

  assign mem_ready = MEM_WAIT_EN ? bus.iMemReady : 1'b1;
  assign is_muldiv = MULDIV_EN && (funct7 == FUNCT7_MULDIV);
  // SUB/SRA are the only funct7=0x20 encodings; M extension only when enabled
  assign r_legal   = (funct7 == FUNCT7_BASE) ||
                     ((funct7 == FUNCT7_SUB) && ((funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SRL))) ||
                     is_muldiv;

  logic [ALU_W-1:0] r_op, i_op;

  always_comb begin
    r_op = OPNULL;
    if (is_muldiv) begin
      case (funct3)
        3'b000:  r_op = OPMUL;
        3'b001:  r_op = OPMULH;
        3'b010:  r_op = OPMULHSU;
        3'b011:  r_op = OPMULHU;
        3'b100:  r_op = OPDIV;
        3'b101:  r_op = OPDIVU;
        3'b110:  r_op = OPREM;
        default: r_op = OPREMU;
      endcase
    end else begin
      case (funct3)
        FUNCT3_ADD:  r_op = (funct7 == FUNCT7_SUB) ? OPSUB : OPADD;
        FUNCT3_SLL:  r_op = OPSLL;
        FUNCT3_SLT:  r_op = OPSLT;
        FUNCT3_SLTU: r_op = OPSLTU;
        FUNCT3_XOR:  r_op = OPXOR;
        FUNCT3_SRL:  r_op = (funct7 == FUNCT7_SUB) ? OPSRA : OPSRL;
        FUNCT3_OR:   r_op = OPOR;
        default:     r_op = OPAND;
      endcase
    end
  end

  // Immediate forms: no SUBI, so only the shift-right picks up funct7
  always_comb begin
    i_op = OPNULL;
    case (funct3)
      FUNCT3_ADD:  i_op = OPADD;
      FUNCT3_SLL:  i_op = OPSLL;
      FUNCT3_SLT:  i_op = OPSLT;
      FUNCT3_SLTU: i_op = OPSLTU;
      FUNCT3_XOR:  i_op = OPXOR;
      FUNCT3_SRL:  i_op = (funct7 == FUNCT7_SUB) ? OPSRA : OPSRL;
      FUNCT3_OR:   i_op = OPOR;
      default:     i_op = OPAND;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  logic             escreve_ir, escreve_pc, escreve_pc_cond, escreve_pc_back;
  logic             iou_d, mem_read, mem_write, reg_write, illegal;
  logic [1:0]       orig_a, orig_b, mem2reg, orig_pc;
  logic [ALU_W-1:0] alu_ctl;

  always_comb begin
    state_d         = state_q;
    escreve_ir      = 1'b0;
    escreve_pc      = 1'b0;
    escreve_pc_cond = 1'b0;
    escreve_pc_back = 1'b0;
    iou_d           = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    reg_write       = 1'b0;
    illegal         = 1'b0;
    orig_a          = 2'b00;
    orig_b          = 2'b00;
    mem2reg         = 2'b00;
    orig_pc         = 2'b00;
    alu_ctl         = OPNULL;

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        orig_a   = 2'b01;
        orig_b   = 2'b01;
        alu_ctl  = OPADD;
        if (mem_ready) begin
          escreve_ir      = 1'b1;
          escreve_pc      = 1'b1;
          escreve_pc_back = 1'b1;
          state_d         = ST_DECODE;
        end
      end
      ST_DECODE: begin
        orig_a  = 2'b10;
        orig_b  = 2'b10;
        alu_ctl = OPADD;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = ST_ADDR;
          OPC_OPIMM:           state_d = ST_I_EXEC;
          OPC_RTYPE:           state_d = r_legal ? ST_R_EXEC : ST_ILLEGAL;
          OPC_AUIPC:           state_d = ST_AUIPC;
          OPC_LUI:             state_d = ST_LUI;
          OPC_BRANCH:          state_d = ST_BRANCH;
          OPC_JAL:             state_d = ST_JAL;
          OPC_JALR:            state_d = ST_JALR;
          default:             state_d = ST_ILLEGAL;
        endcase
      end
      ST_ADDR: begin
        orig_b  = 2'b10;
        alu_ctl = OPADD;
        state_d = (opcode == OPC_LOAD) ? ST_LW_MEM : ST_SW_MEM;
      end
      ST_LW_MEM: begin
        iou_d    = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = ST_LW_WB;
      end
      ST_LW_WB: begin
        mem2reg   = 2'b10;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_SW_MEM: begin
        iou_d     = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_R_EXEC: begin
        alu_ctl = r_op;
        if (!is_muldiv || bus.iMulDivDone) state_d = ST_ALU_WB;
      end
      ST_I_EXEC: begin
        orig_b  = 2'b10;
        alu_ctl = i_op;
        state_d = ST_ALU_WB;
      end
      ST_AUIPC: begin
        orig_a  = 2'b10;
        orig_b  = 2'b10;
        alu_ctl = OPADD;
        state_d = ST_ALU_WB;
      end
      ST_LUI: begin
        orig_b  = 2'b10;
        alu_ctl = OPLUI;
        state_d = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_ctl         = OPSUB;
        escreve_pc_cond = 1'b1;
        orig_pc         = 2'b01;
        state_d         = ST_FETCH;
      end
      ST_JAL: begin
        mem2reg    = 2'b01;
        reg_write  = 1'b1;
        escreve_pc = 1'b1;
        orig_pc    = 2'b10;
        state_d    = ST_FETCH;
      end
      ST_JALR: begin
        orig_b     = 2'b10;
        alu_ctl    = OPADD;
        mem2reg    = 2'b01;
        reg_write  = 1'b1;
        escreve_pc = 1'b1;
        orig_pc    = 2'b11;
        state_d    = ST_FETCH;
      end
      ST_ILLEGAL: begin
        illegal = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset blanks every output immediately, aborting any in-flight access
  assign bus.oEscreveIR     = iRST & escreve_ir;
  assign bus.oEscrevePC     = iRST & escreve_pc;
  assign bus.oEscrevePCCond = iRST & escreve_pc_cond;
  assign bus.oEscrevePCBack = iRST & escreve_pc_back;
  assign bus.oIouD          = iRST & iou_d;
  assign bus.oMemRead       = iRST & mem_read;
  assign bus.oMemWrite      = iRST & mem_write;
  assign bus.oRegWrite      = iRST & reg_write;
  assign bus.oIllegal       = iRST & illegal;
  assign bus.oOrigAULA      = iRST ? orig_a  : 2'b00;
  assign bus.oOrigBULA      = iRST ? orig_b  : 2'b00;
  assign bus.oMem2Reg       = iRST ? mem2reg : 2'b00;
  assign bus.oOrigPC        = iRST ? orig_pc : 2'b00;
  assign bus.oALUControl    = iRST ? alu_ctl : OPNULL;
  assign bus.oState         = iRST ? state_q : ST_FETCH;

endmodule
